// File: rtl/l1c_mem_arbiter.sv
// Round-robin arbiter sharing one wrapper memory port between L1 I-cache and D-cache,
// grant locked per transaction. Optional counters: define L1C_ARB_STATS_EN.
module l1c_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_req,
    input  logic [ADDR_W-1:0] I_addr,
    output logic [DATA_W-1:0] I_out,
    output logic              I_wait,
    input  logic              D_req,
    input  logic              D_write,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [DATA_W-1:0] D_in,
    input  logic [2:0]        D_type,
    output logic [DATA_W-1:0] D_out,
    output logic              D_wait,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_len,
    output logic [2:0]        mem_type,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_bdone
);

    localparam int                CNT_W      = $clog2(BURST_LEN);
    localparam int                LINE_BYTES = BURST_LEN * DATA_W / 8;
    localparam logic [ADDR_W-1:0] LINE_MASK  = ~(ADDR_W'(LINE_BYTES - 1));
    localparam logic [2:0]        TYPE_WORD  = 3'b010;
    localparam logic [1:0]        RD_LEN     = 2'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_RDATA, S_WRESP, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                gnt_d_q, gnt_d_d;   // 1 = D side owns the port
    logic                last_d_q, last_d_d; // 1 = D won the last arbitration
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [1:0]          mem_len_q, mem_len_d;
    logic [2:0]          mem_type_q, mem_type_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   i_out_q, i_out_d;
    logic [DATA_W-1:0]   d_out_q, d_out_d;
    logic                i_win;

    assign i_win = I_req && (!D_req || last_d_q);

    always_comb begin
        state_d     = state_q;
        gnt_d_d     = gnt_d_q;
        last_d_d    = last_d_q;
        beat_cnt_d  = beat_cnt_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_len_d   = mem_len_q;
        mem_type_d  = mem_type_q;
        mem_wdata_d = mem_wdata_q;
        i_out_d     = i_out_q;
        d_out_d     = d_out_q;
        case (state_q)
            S_IDLE: begin
                if (I_req || D_req) begin
                    state_d   = S_REQ;
                    mem_req_d = 1'b1;
                    if (i_win) begin
                        gnt_d_d     = 1'b0;
                        last_d_d    = 1'b0;
                        mem_write_d = 1'b0;
                        mem_addr_d  = I_addr & LINE_MASK;
                        mem_len_d   = RD_LEN;
                        mem_type_d  = TYPE_WORD;
                    end else begin
                        gnt_d_d     = 1'b1;
                        last_d_d    = 1'b1;
                        mem_write_d = D_write;
                        // stores go out at the exact byte address, refills at the line base
                        mem_addr_d  = D_write ? D_addr : (D_addr & LINE_MASK);
                        mem_len_d   = D_write ? 2'd0 : RD_LEN;
                        mem_type_d  = D_type;
                        mem_wdata_d = D_in;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_write_q ? S_WRESP : S_RDATA;
                end
            end
            S_RDATA: begin
                if (mem_rvalid) begin
                    if (gnt_d_q) d_out_d = mem_rdata;
                    else         i_out_d = mem_rdata;
                    if (beat_cnt_q == LAST_BEAT) state_d = S_DONE;
                    else                         beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            S_WRESP: begin
                if (mem_bdone) state_d = S_DONE;
            end
            S_DONE: begin
                beat_cnt_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_d_q     <= 1'b0;
            last_d_q    <= 1'b0;
            beat_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_len_q   <= '0;
            mem_type_q  <= '0;
            mem_wdata_q <= '0;
            i_out_q     <= '0;
            d_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            gnt_d_q     <= gnt_d_d;
            last_d_q    <= last_d_d;
            beat_cnt_q  <= beat_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_len_q   <= mem_len_d;
            mem_type_q  <= mem_type_d;
            mem_wdata_q <= mem_wdata_d;
            i_out_q     <= i_out_d;
            d_out_q     <= d_out_d;
        end
    end

    // Wait drops in the cycle the beat/response is on the bus; the beat lands in X_out at that cycle's edge.
    assign I_wait = !(state_q == S_RDATA && !gnt_d_q && mem_rvalid);
    assign D_wait = !((state_q == S_RDATA && gnt_d_q && mem_rvalid) ||
                      (state_q == S_WRESP && gnt_d_q && mem_bdone));

    assign I_out     = i_out_q;
    assign D_out     = d_out_q;
    assign mem_req   = mem_req_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_len   = mem_len_q;
    assign mem_type  = mem_type_q;
    assign mem_wdata = mem_wdata_q;

`ifdef L1C_ARB_STATS_EN
    logic [31:0] arb_i_grants, arb_d_grants, arb_conflicts, arb_i_stall;
    logic        arb_pick;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    assign arb_pick = (state_q == S_IDLE) && (I_req || D_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            arb_i_grants  <= '0;
            arb_d_grants  <= '0;
            arb_conflicts <= '0;
            arb_i_stall   <= '0;
        end else begin
            arb_i_grants  <= sat_inc(arb_i_grants, arb_pick && i_win);
            arb_d_grants  <= sat_inc(arb_d_grants, arb_pick && !i_win);
            arb_conflicts <= sat_inc(arb_conflicts, state_q == S_IDLE && I_req && D_req);
            arb_i_stall   <= sat_inc(arb_i_stall, I_req && state_q != S_IDLE && gnt_d_q);
        end
    end
`endif

endmodule

// File: tb/tb_l1c_mem_arbiter.sv
// Self-checking bench for l1c_mem_arbiter: vector table, corner-case sequences and
// randomized transactions checked against a transaction-level round-robin model.
module tb_l1c_mem_arbiter;

    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_req, D_req, D_write, mem_ack, mem_rvalid, mem_bdone;
    logic [31:0] I_addr, D_addr, D_in, mem_rdata;
    logic [2:0]  D_type;
    logic [31:0] I_out, D_out, mem_addr, mem_wdata;
    logic        I_wait, D_wait, mem_req, mem_write;
    logic [1:0]  mem_len;
    logic [2:0]  mem_type;

    int          n_chk  = 0;
    int          n_pass = 0;
    bit          last_d;          // model: 1 = D won the most recent arbitration

    l1c_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .I_req(I_req), .I_addr(I_addr), .I_out(I_out), .I_wait(I_wait),
        .D_req(D_req), .D_write(D_write), .D_addr(D_addr), .D_in(D_in), .D_type(D_type),
        .D_out(D_out), .D_wait(D_wait),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_type(mem_type), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_bdone(mem_bdone)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  typ;
        logic [31:0] e_addr;
        logic [1:0]  e_len;
        logic [2:0]  e_type;
        int          ack_dly;
        int          gap;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; I_req = 0; D_req = 0; mem_ack = 0; mem_rvalid = 0; mem_bdone = 0;
        tick(); tick();
        rst = 1'b0;
        last_d = 1'b0;
    endtask

    task automatic start_i(input logic [31:0] a);
        I_req = 1'b1; I_addr = a;
    endtask

    task automatic start_d(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] t);
        D_req = 1'b1; D_write = w; D_addr = a; D_in = wd; D_type = t;
    endtask

    // Entered in the first REQ cycle; returns in the IDLE cycle after DONE.
    task automatic run_txn(input bit gd, input logic [31:0] e_addr, input logic [1:0] e_len,
                           input bit e_wr, input logic [2:0] e_type, input logic [31:0] e_wd,
                           input int ack_dly, input int gap, input bit drop, input bit stray,
                           input bit raise);
        logic [31:0] dat;
        chk("req_hi", {31'd0, mem_req}, 32'd1);
        chk("req_addr", mem_addr, e_addr);
        chk("req_len", {30'd0, mem_len}, {30'd0, e_len});
        chk("req_write", {31'd0, mem_write}, {31'd0, e_wr});
        chk("req_type", {29'd0, mem_type}, {29'd0, e_type});
        if (e_wr) chk("req_wdata", mem_wdata, e_wd);
        for (int k = 0; k <= ack_dly; k++) begin
            mem_ack    = (k == ack_dly);
            mem_rvalid = stray && k < ack_dly && ($urandom_range(0, 1) == 1);
            mem_bdone  = stray && k < ack_dly && ($urandom_range(0, 1) == 1);
            #1;
            chk("req_held", {31'd0, mem_req}, 32'd1);
            chk("req_iwait", {31'd0, I_wait}, 32'd1);
            chk("req_dwait", {31'd0, D_wait}, 32'd1);
            tick();
            mem_ack = 0; mem_rvalid = 0; mem_bdone = 0;
        end
        chk("req_drop", {31'd0, mem_req}, 32'd0);
        if (drop) begin
            if (gd) D_req = 1'b0;
            else    I_req = 1'b0;
        end
        if (!e_wr) begin
            for (int b = 0; b < BL; b++) begin
                for (int g = 0; g < gap; g++) begin
                    mem_bdone = stray && ($urandom_range(0, 1) == 1);
                    #1;
                    chk("gap_iwait", {31'd0, I_wait}, 32'd1);
                    chk("gap_dwait", {31'd0, D_wait}, 32'd1);
                    tick();
                    mem_bdone = 0;
                end
                if (raise && b == 0) begin
                    if (gd) start_i(32'h0000_2008);
                    else    start_d(1'b0, 32'h0000_3000, 32'd0, 3'b010);
                end
                dat = $urandom;
                mem_rvalid = 1'b1; mem_rdata = dat;
                #1;
                chk("beat_iwait", {31'd0, I_wait}, {31'd0, gd});
                chk("beat_dwait", {31'd0, D_wait}, {31'd0, !gd});
                tick();
                mem_rvalid = 1'b0;
                if (gd) chk("beat_dout", D_out, dat);
                else    chk("beat_iout", I_out, dat);
            end
        end else begin
            for (int g = 0; g < gap; g++) begin
                mem_rvalid = stray && ($urandom_range(0, 1) == 1);
                #1;
                chk("wr_iwait", {31'd0, I_wait}, 32'd1);
                chk("wr_dwait", {31'd0, D_wait}, 32'd1);
                tick();
                mem_rvalid = 0;
            end
            mem_bdone = 1'b1;
            #1;
            chk("bdone_dwait", {31'd0, D_wait}, 32'd0);
            chk("bdone_iwait", {31'd0, I_wait}, 32'd1);
            tick();
            mem_bdone = 1'b0;
        end
        // DONE cycle: requester lets go of its request here
        if (gd) D_req = 1'b0;
        else    I_req = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk("done_iwait", {31'd0, I_wait}, 32'd1);
        chk("done_dwait", {31'd0, D_wait}, 32'd1);
        chk("done_req", {31'd0, mem_req}, 32'd0);
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic exp_txn(input bit gd, output logic [31:0] ea, output logic [1:0] el,
                           output bit ew, output logic [2:0] et);
        if (gd) begin
            ew = D_write;
            ea = D_write ? D_addr : D_addr - (D_addr % 32'(BL * 4));
            el = D_write ? 2'd0 : 2'(BL - 1);
            et = D_type;
        end else begin
            ew = 1'b0;
            ea = I_addr - (I_addr % 32'(BL * 4));
            el = 2'(BL - 1);
            et = 3'b010;
        end
    endtask

    initial begin
        logic [31:0] ea;
        logic [1:0]  el;
        logic [2:0]  et;
        logic [31:0] saved;
        bit          ew, gd;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0,         3'b010, 32'h0000_1230, 2'd3, 3'b010, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 3'b010, 32'h8000_0004, 2'd0, 3'b010, 0, 3};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_ABCF, 32'h0,         3'b000, 32'h0000_ABC0, 2'd3, 3'b000, 2, 1};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         3'b010, 32'hFFFF_FFF0, 2'd3, 3'b010, 1, 2};
        vecs[4] = '{1'b1, 1'b1, 32'h1234_5677, 32'h0,         3'b001, 32'h1234_5677, 2'd0, 3'b001, 0, 0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         3'b100, 32'h0000_0010, 2'd3, 3'b100, 3, 0};

        I_addr = 0; D_addr = 0; D_in = 0; D_type = 0; D_write = 0; mem_rdata = 0;
        do_reset();

        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_len", {30'd0, mem_len}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_iwait", {31'd0, I_wait}, 32'd1);
        chk("rst_dwait", {31'd0, D_wait}, 32'd1);
        chk("rst_iout", I_out, 32'd0);
        chk("rst_dout", D_out, 32'd0);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].is_d) start_d(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].typ);
            else              start_i(vecs[v].addr);
            tick();
            run_txn(vecs[v].is_d, vecs[v].e_addr, vecs[v].e_len, vecs[v].wr, vecs[v].e_type,
                    vecs[v].wdata, vecs[v].ack_dly, vecs[v].gap, 1'b0, 1'b0, 1'b0);
        end

        // tie after reset: D first, then I; tie after a D win: I first
        do_reset();
        start_d(1'b0, 32'h0000_0040, 32'd0, 3'b000);
        start_i(32'h0000_0084);
        tick();
        run_txn(1'b1, 32'h0000_0040, 2'd3, 1'b0, 3'b000, 32'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        tick();
        run_txn(1'b0, 32'h0000_0080, 2'd3, 1'b0, 3'b010, 32'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        start_d(1'b1, 32'h0000_0102, 32'h1111_2222, 3'b001);
        tick();
        run_txn(1'b1, 32'h0000_0102, 2'd0, 1'b1, 3'b001, 32'h1111_2222, 1, 1, 1'b0, 1'b0, 1'b0);
        start_d(1'b0, 32'h0000_0200, 32'd0, 3'b010);
        start_i(32'h0000_0300);
        tick();
        run_txn(1'b0, 32'h0000_0300, 2'd3, 1'b0, 3'b010, 32'd0, 0, 1, 1'b0, 1'b0, 1'b0);
        tick();
        run_txn(1'b1, 32'h0000_0200, 2'd3, 1'b0, 3'b010, 32'd0, 0, 0, 1'b0, 1'b0, 1'b0);

        // I raised during a D burst waits, then is served
        start_d(1'b0, 32'h0000_0400, 32'd0, 3'b010);
        tick();
        run_txn(1'b1, 32'h0000_0400, 2'd3, 1'b0, 3'b010, 32'd0, 1, 1, 1'b0, 1'b0, 1'b1);
        tick();
        run_txn(1'b0, 32'h0000_2000, 2'd3, 1'b0, 3'b010, 32'd0, 0, 0, 1'b0, 1'b0, 1'b0);

        // stray rvalid in IDLE is ignored; dropped I_req still gets all beats
        saved = I_out;
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        #1;
        chk("stray_iwait", {31'd0, I_wait}, 32'd1);
        chk("stray_dwait", {31'd0, D_wait}, 32'd1);
        tick();
        mem_rvalid = 1'b0;
        chk("stray_req", {31'd0, mem_req}, 32'd0);
        chk("stray_iout", I_out, saved);
        start_i(32'h0000_0604);
        tick();
        run_txn(1'b0, 32'h0000_0600, 2'd3, 1'b0, 3'b010, 32'd0, 1, 1, 1'b1, 1'b1, 1'b0);

        // reset after the second beat
        start_i(32'h0000_0500);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0000 + b;
            tick();
        end
        mem_rvalid = 1'b0;
        rst = 1'b1; I_req = 1'b0;
        tick();
        rst = 1'b0;
        last_d = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        chk("mid_rst_iwait", {31'd0, I_wait}, 32'd1);
        chk("mid_rst_dwait", {31'd0, D_wait}, 32'd1);
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_iout", I_out, 32'd0);
        tick();
        mem_rvalid = 1'b0;
        chk("post_rst_iout", I_out, 32'd0);
        chk("post_rst_req", {31'd0, mem_req}, 32'd0);
        start_i(32'h0000_1234);
        tick();
        run_txn(1'b0, 32'h0000_1230, 2'd3, 1'b0, 3'b010, 32'd0, 0, 0, 1'b0, 1'b0, 1'b0);

        // randomized traffic against the round-robin model
        for (int n = 0; n < 40; n++) begin
            if (!I_req && $urandom_range(0, 2) != 0) start_i($urandom);
            if (!D_req && $urandom_range(0, 2) != 0)
                start_d($urandom_range(0, 1) == 1, $urandom, $urandom, 3'($urandom_range(0, 5)));
            if (!I_req && !D_req) start_i($urandom);
            gd = (I_req && D_req) ? !last_d : D_req;
            exp_txn(gd, ea, el, ew, et);
            last_d = gd;
            tick();
            run_txn(gd, ea, el, ew, et, D_in, $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
